// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if: PE control bundle between the host-side sequencer and the PE.
// The sequencer drives the load and instruction paths; the PE returns write-backs.
`timescale 1ns/1ps
interface pe_sequencer_if #(
  parameter int INST_WIDTH = 64,
  parameter int DATA_WIDTH = 16
);
  logic                    inst_v;
  logic [INST_WIDTH-1:0]   inst;
  logic                    din_ld_v;
  logic [DATA_WIDTH*2-1:0] din_ld;
  logic                    dout_v;
  logic [DATA_WIDTH*2-1:0] dout;

  modport master (
    output inst_v, inst, din_ld_v, din_ld,
    input  dout_v, dout
  );

  modport slave (
    input  inst_v, inst, din_ld_v, din_ld,
    output dout_v, dout
  );
endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer: holds a small program and issues it to the PE one word per cycle,
// counts instructions in flight against returning write-backs and pulses done once
// the PE pipeline has drained. Define PE_SEQ_TIMEOUT_EN to build the drain watchdog;
// without it err is tied low and DRAIN waits indefinitely.
`timescale 1ns/1ps
module pe_sequencer #(
  parameter int  INST_WIDTH = 64,
  parameter int  DATA_WIDTH = 16,
  parameter int  PROG_DEPTH = 16,
  parameter int  TIMEOUT    = 64,
  localparam int AW         = $clog2(PROG_DEPTH),
  localparam int DW         = DATA_WIDTH * 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we_i,
  input  logic [AW-1:0]         prog_addr_i,
  input  logic [INST_WIDTH-1:0] prog_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  result_v_o,
  output logic [DW-1:0]         result_o,
  output logic [7:0]            result_cnt_o,
  pe_sequencer_if.master        pe_if
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [AW-1:0]         rd_addr;
  logic [INST_WIDTH-1:0] mem_q [PROG_DEPTH];
  logic [INST_WIDTH-1:0] rdata_q;
  logic [3:0]            outst_q, outst_d;
  logic                  inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  din_ld_v_q, din_ld_v_d;
  logic [DW-1:0]         din_ld_q, din_ld_d;
  logic                  result_v_q;
  logic [DW-1:0]         result_q;
  logic [7:0]            result_cnt_q;
  logic                  start_ok;
  logic                  prog_wr;
  logic                  issue;
  logic                  drain_empty;
  logic                  wd_fire;
  logic [2:0]            opcode;

  assign start_ok = (state_q == S_IDLE) && start_i;
  assign prog_wr  = (state_q == S_IDLE) && prog_we_i;
  assign opcode   = rdata_q[31:29];

  // rdata_q holds the word at pc_q while running, so the next read is pc_q+1;
  // an accepted start primes the read port with word 0 instead.
  assign rd_addr = start_ok ? '0 : pc_q + 1'b1;

  // DRAIN only ever decrements, so the count is about to hit zero when it is
  // already zero or a single outstanding instruction is returning right now.
  assign drain_empty = (outst_q == 4'd0) || ((outst_q == 4'd1) && pe_if.dout_v);

  // Program store: written only while idle; registered read with write-first
  // forwarding so a word written on the start edge is the one fetched.
  always_ff @(posedge clk) begin
    if (prog_wr) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
    if (prog_wr && (prog_addr_i == rd_addr)) begin
      rdata_q <= prog_data_i;
    end else begin
      rdata_q <= mem_q[rd_addr];
    end
  end

  // Next-state, issue decode and outstanding-count update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    inst_v_d   = 1'b0;
    inst_d     = inst_q;
    din_ld_v_d = 1'b0;
    din_ld_d   = din_ld_q;
    outst_d    = outst_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        pc_d = pc_q + 1'b1;
        if (opcode == OP_HALT) begin
          // The word being fetched behind the HALT is dropped by leaving RUN.
          state_d = S_DRAIN;
        end else begin
          if (opcode == OP_LOAD) begin
            din_ld_v_d = 1'b1;
            din_ld_d   = rdata_q[32 +: DW];
          end else begin
            inst_v_d = 1'b1;
            inst_d   = rdata_q;
            issue    = 1'b1;
          end
          if (pc_q == AW'(PROG_DEPTH - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_empty || wd_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write-back against an empty count is a stray and leaves it at zero.
    if (wd_fire) begin
      outst_d = '0;
    end else if (issue && !pe_if.dout_v && (outst_q != 4'hF)) begin
      outst_d = outst_q + 1'b1;
    end else if (!issue && pe_if.dout_v && (outst_q != 4'd0)) begin
      outst_d = outst_q - 1'b1;
    end
  end

  // Control state and PE-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      outst_q    <= '0;
      inst_v_q   <= 1'b0;
      inst_q     <= '0;
      din_ld_v_q <= 1'b0;
      din_ld_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      inst_v_q   <= inst_v_d;
      inst_q     <= inst_d;
      din_ld_v_q <= din_ld_v_d;
      din_ld_q   <= din_ld_d;
    end
  end

  // Write-back capture runs in every state, including after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_v_q   <= 1'b0;
      result_q     <= '0;
      result_cnt_q <= '0;
    end else begin
      result_v_q <= pe_if.dout_v;
      if (pe_if.dout_v) begin
        result_q <= pe_if.dout;
      end
      if (start_ok) begin
        result_cnt_q <= '0;
      end else if (pe_if.dout_v && (result_cnt_q != 8'hFF)) begin
        result_cnt_q <= result_cnt_q + 8'd1;
      end
    end
  end

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  // Fires on the TIMEOUT-th DRAIN cycle without a write-back while work is pending.
  assign wd_fire = (state_q == S_DRAIN) && (outst_q != 4'd0) && !pe_if.dout_v &&
                   (wd_q == WDW'(TIMEOUT - 1));

  // Watchdog count restarts on entry to DRAIN and on every write-back.
  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if ((state_q != S_DRAIN) || pe_if.dout_v) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
    if (start_ok) begin
      err_d = 1'b0;
    end else if (wd_fire) begin
      err_d = 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign wd_fire = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);
  assign result_v_o     = result_v_q;
  assign result_o       = result_q;
  assign result_cnt_o   = result_cnt_q;
  assign pe_if.inst_v   = inst_v_q;
  assign pe_if.inst     = inst_q;
  assign pe_if.din_ld_v = din_ld_v_q;
  assign pe_if.din_ld   = din_ld_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: randomized and directed runs of pe_sequencer against a
// program-level reference model and a 6-cycle PE write-back model.
`timescale 1ns/1ps
module tb_pe_sequencer;
  localparam int TMO = 8;
  localparam logic [2:0] OP_HALT = 3'b011;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [63:0] prog_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        result_v;
  logic [31:0] result;
  logic [7:0]  result_cnt;

  logic [63:0] prog [16];
  logic [31:0] exp_q [$];
  logic [32:0] pipe [7];
  bit          pe_mute;
  int          checks;
  int          failures;

  pe_sequencer_if #(.INST_WIDTH(64), .DATA_WIDTH(16)) pe_if ();

  pe_sequencer #(
    .INST_WIDTH(64), .DATA_WIDTH(16), .PROG_DEPTH(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err),
    .result_v_o(result_v), .result_o(result), .result_cnt_o(result_cnt),
    .pe_if(pe_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input logic [2:0] op, input logic [31:0] hi);
    logic [31:0] lo;
    lo = $urandom;
    return {hi, op, lo[28:0]};
  endfunction

  // PE model: returns the upper half of each issued instruction 6 cycles later,
  // and checks captured results against the write-backs it produced.
  initial begin
    logic [31:0] e;
    for (int i = 0; i < 7; i++) pipe[i] = '0;
    pe_if.dout_v = 1'b0;
    pe_if.dout   = '0;
    forever begin
      @(negedge clk);
      if (result_v) begin
        if (exp_q.size() == 0) begin
          check("result_extra", 64'(result_v), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e));
        end
      end
      for (int i = 6; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {pe_if.inst_v & ~pe_mute, pe_if.inst[63:32]};
      pe_if.dout_v = pipe[6][32];
      pe_if.dout   = pipe[6][31:0];
      if (pipe[6][32]) exp_q.push_back(pipe[6][31:0]);
    end
  end

  task automatic load_prog();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(k);
      prog_data = prog[k];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One run from start to idle. Model: words up to the first HALT (or all 16)
  // issue at start+2+index; done follows the later of DRAIN entry and the last
  // write-back (or the watchdog limit when the PE is silent).
  task automatic run_prog(input bit poke, input bit wr0, input logic [63:0] w0, input bit expect_wd);
    int n, jl, ncomp, doff, idx;
    bit halted, ev_ld, ev_in;
    logic [2:0] op;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = w0;
      prog[0]   = w0;
    end
    n = 0; jl = -1; ncomp = 0; halted = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!halted) begin
        op = prog[k][31:29];
        if (op == OP_HALT) halted = 1'b1;
        else begin
          n++;
          if (op != 3'b000) begin jl = k; ncomp++; end
        end
      end
    end
    if (expect_wd) doff = 2 + n + TMO;
    else if (jl < 0) doff = 3 + n;
    else doff = (3 + n > 9 + jl) ? 3 + n : 9 + jl;

    for (int m = 1; m <= doff + 1; m++) begin
      @(negedge clk);
      if (m == 1) begin start = 1'b0; prog_we = 1'b0; end
      if (poke && m == 3) begin
        start = 1'b1; prog_we = 1'b1;
        prog_addr = 4'($urandom_range(0, 15));
        prog_data = {$urandom, $urandom};
      end
      if (poke && m == 4) begin start = 1'b0; prog_we = 1'b0; end
      idx   = m - 2;
      ev_ld = (idx >= 0) && (idx < n) && (prog[idx < 0 ? 0 : idx][31:29] == 3'b000);
      ev_in = (idx >= 0) && (idx < n) && !ev_ld;
      check("inst_v", 64'(pe_if.inst_v), 64'(ev_in));
      if (ev_in) check("inst", pe_if.inst, prog[idx]);
      check("din_ld_v", 64'(pe_if.din_ld_v), 64'(ev_ld));
      if (ev_ld) check("din_ld", 64'(pe_if.din_ld), 64'(prog[idx][63:32]));
      check("busy", 64'(busy), 64'(m < doff));
      check("done", 64'(done), 64'(m == doff));
      check("err", 64'(err), 64'(expect_wd && (m >= doff)));
    end
    check("result_cnt", 64'(result_cnt), expect_wd ? 64'd0 : 64'(ncomp));
    check("result_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0; pe_mute = 1'b0;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_inst_v", 64'(pe_if.inst_v), 64'd0);
    check("rst_din_ld_v", 64'(pe_if.din_ld_v), 64'd0);
    check("rst_inst", pe_if.inst, 64'd0);
    check("rst_din_ld", 64'(pe_if.din_ld), 64'd0);
    check("rst_result_v", 64'(result_v), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_cnt", 64'(result_cnt), 64'd0);
    rst = 1'b0;

    // LOAD then HALT
    for (int k = 0; k < 16; k++) prog[k] = mkword(3'($urandom_range(0, 7)), $urandom);
    prog[0] = mkword(3'b000, 32'h1234_5678);
    prog[1] = mkword(OP_HALT, $urandom);
    load_prog();
    run_prog(1'b0, 1'b0, 64'd0, 1'b0);

    // Four computes then HALT; PE echoes 0xA0..0xA3
    for (int k = 0; k < 4; k++) prog[k] = mkword(3'b001, 32'hA0 + 32'(k));
    prog[4] = mkword(OP_HALT, $urandom);
    load_prog();
    run_prog(1'b0, 1'b0, 64'd0, 1'b0);

    // Sixteen computes, no HALT, with ignored start/prog_we while busy
    for (int k = 0; k < 16; k++) prog[k] = mkword(3'b001 + 3'($urandom_range(0, 1)) * 3'd3, $urandom);
    load_prog();
    run_prog(1'b1, 1'b0, 64'd0, 1'b0);
    run_prog(1'b0, 1'b0, 64'd0, 1'b0);

    // Abort with rst after three issues, then rerun unchanged
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_inst_v", 64'(pe_if.inst_v), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_inst_v", 64'(pe_if.inst_v), 64'd0);
    check("abort_inst", pe_if.inst, 64'd0);
    check("abort_din_ld_v", 64'(pe_if.din_ld_v), 64'd0);
    check("abort_result_cnt", 64'(result_cnt), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort_idle_busy", 64'(busy), 64'd0);
    end
    check("abort_stray_cnt", 64'(result_cnt), 64'd3);
    run_prog(1'b0, 1'b0, 64'd0, 1'b0);

    // Randomized programs; some with a start-edge rewrite of word 0 or busy pokes
    for (int t = 0; t < 6; t++) begin
      logic [2:0] op;
      for (int k = 0; k < 16; k++) begin
        op = 3'($urandom_range(0, 7));
        if (op == OP_HALT && $urandom_range(0, 2) != 0) op = 3'b101;
        prog[k] = mkword(op, $urandom);
      end
      load_prog();
      run_prog((t % 2) == 1, (t == 2) || (t == 5),
               mkword(3'($urandom_range(0, 7)), $urandom), 1'b0);
      run_prog(1'b0, 1'b0, 64'd0, 1'b0);
    end

`ifdef PE_SEQ_TIMEOUT_EN
    // Silent PE: watchdog ends the run with err, next start clears it
    prog[0] = mkword(3'b001, $urandom);
    prog[1] = mkword(OP_HALT, $urandom);
    load_prog();
    pe_mute = 1'b1;
    run_prog(1'b0, 1'b0, 64'd0, 1'b1);
    pe_mute = 1'b0;
    run_prog(1'b0, 1'b0, 64'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Instruction issuer and write-back collector on the host side of the PE control interface. It holds a small program of 64-bit words and drives the PE load path (`din_ld_v`/`din_ld`) and instruction path (`inst_v`/`inst`) at one word per cycle. It counts instructions in flight against returning write-backs (`dout_v`/`dout`) and reports completion once the PE pipeline has fully drained.

## Interface
- `INST_WIDTH`, 64: program word width. The opcode is in bits [31:29].
- `DATA_WIDTH`, 16: half data width. Data buses are `DATA_WIDTH*2` = 32 bits.
- `PROG_DEPTH`, 16: number of program words. Must be a power of two.
- `TIMEOUT`, 64: drain watchdog limit in cycles. Used only with `PE_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `prog_we` in 1: program write strobe. Honoured only in IDLE.
- `prog_addr` in log2(PROG_DEPTH): program write address.
- `prog_data` in INST_WIDTH: program write data.
- `start` in 1: begin execution at pc=0. Honoured only in IDLE.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the run completes.
- `err` out 1: watchdog fired. Sticky until the next accepted `start` or `rst`.
- `inst_v` out 1: instruction valid to the PE.
- `inst` out INST_WIDTH: instruction word to the PE.
- `din_ld_v` out 1: load-data valid to the PE.
- `din_ld` out DATA_WIDTH*2: load data, taken from program word bits [63:32].
- `dout_v` in 1: write-back valid from the PE.
- `dout` in DATA_WIDTH*2: write-back data from the PE.
- `result_v` out 1: registered copy of `dout_v`.
- `result` out DATA_WIDTH*2: registered copy of `dout`.
- `result_cnt` out 8: number of write-backs captured since the last accepted `start`.

## Operation
- Program memory: synchronous write and synchronous (registered) read. Contents are not cleared by `rst`.
- Word classes by opcode [31:29]:
  - 000 LOAD: `din_ld_v`=1, `din_ld`=word[63:32], `inst_v`=0.
  - 011 HALT: nothing is issued; fetch stops.
  - 001/010/100/101/110/111 compute: `inst_v`=1, `inst`=word. Outstanding count +1.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`. Set pc=0, clear `result_cnt`, clear `err`.
  - RUN: fetch pc each cycle, pc increments. Go to DRAIN when a HALT word is decoded, or when the word at pc=PROG_DEPTH-1 has been issued (no wrap-around). A word fetched speculatively after HALT is discarded and never issued.
  - DRAIN: stays until the outstanding count is 0, then goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Outstanding counter: 4 bits.
  - Issue and `dout_v` in the same cycle: count unchanged.
  - `dout_v` with count 0: ignored, count stays 0, `result` is still captured.
- Result capture: active in every state. On `dout_v`, `result` <= `dout`, `result_v` <= 1, and `result_cnt` increments, saturating at 255.
- `prog_we` or `start` outside IDLE: ignored. `start` and `prog_we` together in IDLE: the write happens and the run starts, with the new word visible to the fetch.

## Timing
- Reset values, applied on the first rising edge with `rst`=1: state=IDLE, pc=0, outstanding=0, and `busy`, `done`, `err`, `inst_v`, `din_ld_v`, `result_v`, `result_cnt` all 0. `inst`, `din_ld`, `result` are 0.
- `rst` mid-run: aborts immediately. The next cycle shows reset values. In-flight PE write-backs arriving later are captured but cause no state change.
- `start` sampled at edge T: `busy`=1 from T+1. First issue appears at T+2. After that, one word issues per cycle with no bubbles between consecutive non-HALT words.
- All PE-facing outputs are registered. Exactly one of `inst_v` and `din_ld_v` is high in any cycle, or neither.
- The PE returns `dout_v` 6 cycles after `inst_v`. Latency is not hard-coded; drain relies only on the outstanding count.
- `result_v`/`result` lag `dout_v`/`dout` by 1 cycle.
- `done` rises in the cycle after the outstanding count reaches 0 in DRAIN. `busy` falls in the same cycle `done` rises.

## Configuration
- `PE_SEQ_TIMEOUT_EN` defined:
  - DRAIN runs a cycle counter that resets on each `dout_v`.
  - If it reaches `TIMEOUT` with outstanding ≠ 0: `err`=1, outstanding is cleared, FSM goes to DONE.
- `PE_SEQ_TIMEOUT_EN` undefined: no watchdog is built, `err` is tied to 0, and DRAIN waits indefinitely.

## Test plan
- LOAD then HALT: word0 opcode 000 with [63:32]=0x12345678, word1 HALT. `start` at T → `din_ld_v`=1 and `din_ld`=0x12345678 at T+2. `done` pulses at T+4. `result_cnt`=0.
- Four compute words (opcode 001) then HALT, PE model returns `dout`=0xA0..0xA3 after 6 cycles → `inst_v` high T+2..T+5. `result` values 0xA0..0xA3 appear in order. `done` fires one cycle after the last `dout_v`. `result_cnt`=4.
- All 16 words compute, no HALT → 16 consecutive `inst_v`, no wrap to pc=0. `result_cnt`=16 and `done` once.
- `rst` asserted in RUN after 3 issues → next cycle all outputs hold reset values. A later `start` reruns the same program unchanged.
- Watchdog, with `PE_SEQ_TIMEOUT_EN` and `TIMEOUT`=8: one compute word, PE never responds → `err`=1 and `done` pulse 8 cycles after DRAIN is entered. `err` clears on the next `start`.
- `start` and `prog_we` pulsed while `busy` → ignored. Program contents and run sequence are unchanged.
